hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
//
// Outputs are decoded combinationally from the state and the hazard inputs.
// The stall and flush events are also counted.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   ID_rs1/ID_rs2, ID_use_rs1/2   source registers of the ID instruction
//   EX_rd, EX_reg_write,          destination of the EX instruction
//   EX_reg_sel
//   EX_br_taken                   branch/jump in EX resolved taken
//   EX_mdu_op, mdu_done           multi-cycle mul/div handshake inputs
//   halt_req                      debug halt request (level)
//   stall_IF/ID/EX                hold the PC / IF-ID / ID-EX registers
//   flush_ID/EX, bubble_MEM       replace IF-ID / ID-EX / EX-MEM with a NOP
//   mdu_start                     one-cycle MDU start pulse
//   halted                        core frozen in HALT
//   stall_cnt, flush_cnt          saturating event counters
module hazard_ctrl #(
  parameter int         CNT_W   = 16,
  parameter logic [2:0] MEM_OUT = 3'b001
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_reg_write,
  input  logic [2:0]       EX_reg_sel,
  input  logic             EX_br_taken,
  input  logic             EX_mdu_op,
  input  logic             mdu_done,
  input  logic             halt_req,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             bubble_MEM,
  output logic             mdu_start,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MDU_BUSY, HALT} state_t;

  state_t state, state_nxt;
  logic   load_use;
  logic   st_if, st_id, st_ex, fl_id, fl_ex, bub_mem, start, hlt;

  // A load in EX whose result the ID instruction needs next cycle.
  assign load_use = (state == RUN) && EX_reg_write && (EX_reg_sel == MEM_OUT) &&
                    (EX_rd != 5'd0) &&
                    (((EX_rd == ID_rs1) && ID_use_rs1) ||
                     ((EX_rd == ID_rs2) && ID_use_rs2));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    st_if     = 1'b0;
    st_id     = 1'b0;
    st_ex     = 1'b0;
    fl_id     = 1'b0;
    fl_ex     = 1'b0;
    bub_mem   = 1'b0;
    start     = 1'b0;
    hlt       = 1'b0;
    case (state)
      RUN: begin
        // A taken branch kills every younger hazard, so it is checked first.
        if (EX_br_taken) begin
          fl_id = 1'b1;
          fl_ex = 1'b1;
        end else if (EX_mdu_op) begin
          start     = 1'b1;
          {st_if, st_id, st_ex, bub_mem} = 4'b1111;
          state_nxt = MDU_BUSY;
        end else if (load_use) begin
          // The bubble injected into EX clears the hazard by the next cycle.
          st_if = 1'b1;
          st_id = 1'b1;
          fl_ex = 1'b1;
        end else if (halt_req) begin
          {st_if, st_id, st_ex, bub_mem} = 4'b1111;
          state_nxt = HALT;
        end
      end
      MDU_BUSY: begin
        // Branch, load-use and halt are held off until the MDU finishes.
        if (mdu_done) state_nxt = halt_req ? HALT : RUN;
        else          {st_if, st_id, st_ex, bub_mem} = 4'b1111;
      end
      HALT: begin
        if (halt_req) begin
          hlt = 1'b1;
          {st_if, st_id, st_ex, bub_mem} = 4'b1111;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of inputs.
  assign stall_IF   = st_if   & rstn;
  assign stall_ID   = st_id   & rstn;
  assign stall_EX   = st_ex   & rstn;
  assign flush_ID   = fl_id   & rstn;
  assign flush_EX   = fl_ex   & rstn;
  assign bubble_MEM = bub_mem & rstn;
  assign mdu_start  = start   & rstn;
  assign halted     = hlt     & rstn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_IF && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_ID || flush_EX) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 ns later. ctl packs the 1-bit outputs as
// {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, bubble_MEM, mdu_start, halted}.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rstn;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic ID_use_rs1, ID_use_rs2, EX_reg_write, EX_br_taken, EX_mdu_op, mdu_done, halt_req;
  logic [2:0] EX_reg_sel;
  logic stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, bubble_MEM, mdu_start, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic s4_if, s4_id, s4_ex, f4_id, f4_ex, b4_mem, st4, h4;
  logic [3:0] stall_cnt4, flush_cnt4;
  logic [7:0] ctl;
  int tests = 0;
  int fails = 0;

  assign ctl = {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, bubble_MEM, mdu_start, halted};

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rstn(rstn), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
    .EX_reg_write(EX_reg_write), .EX_reg_sel(EX_reg_sel), .EX_br_taken(EX_br_taken),
    .EX_mdu_op(EX_mdu_op), .mdu_done(mdu_done), .halt_req(halt_req),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .bubble_MEM(bubble_MEM),
    .mdu_start(mdu_start), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
    .EX_reg_write(EX_reg_write), .EX_reg_sel(EX_reg_sel), .EX_br_taken(EX_br_taken),
    .EX_mdu_op(EX_mdu_op), .mdu_done(mdu_done), .halt_req(halt_req),
    .stall_IF(s4_if), .stall_ID(s4_id), .stall_EX(s4_ex),
    .flush_ID(f4_id), .flush_EX(f4_ex), .bubble_MEM(b4_mem),
    .mdu_start(st4), .halted(h4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic idle();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
    EX_rd = 5'd0; EX_reg_write = 1'b0; EX_reg_sel = 3'b000; EX_br_taken = 1'b0;
    EX_mdu_op = 1'b0; mdu_done = 1'b0; halt_req = 1'b0;
  endtask

  // Pulse reset across one edge; leaves the bench just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    idle();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic load_use_inputs(input logic [4:0] rd, input logic [2:0] sel);
    EX_rd = rd; EX_reg_write = 1'b1; EX_reg_sel = sel;
    ID_rs2 = 5'd5; ID_use_rs2 = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    halt_req = 1'b1; EX_br_taken = 1'b1; EX_mdu_op = 1'b1;
    rstn = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL reset_outputs ctl=%b expected=%b", ctl, 8'h00);
    end
    tests++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_counters stall=%0d flush=%0d expected=0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    idle();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    load_use_inputs(5'd5, 3'b001);
    #1;
    tests++;
    if (ctl !== 8'b1100_1000) begin
      fails++; $display("FAIL load_use_ctl ctl=%b expected=%b", ctl, 8'b1100_1000);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1 || ctl !== 8'h00) begin
      fails++; $display("FAIL load_use_after stall=%0d flush=%0d ctl=%b expected=1/1/00000000",
                        stall_cnt, flush_cnt, ctl);
    end
    // Destination x0 never creates a hazard.
    load_use_inputs(5'd0, 3'b001);
    ID_rs2 = 5'd0;
    #1;
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL load_use_x0 ctl=%b expected=%b", ctl, 8'h00);
    end
    // Non-load destination (ALU result) does not stall.
    load_use_inputs(5'd5, 3'b000);
    #1;
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL load_use_alu ctl=%b expected=%b", ctl, 8'h00);
    end
    // Matching rs1 that is not actually read does not stall.
    idle();
    EX_rd = 5'd7; EX_reg_write = 1'b1; EX_reg_sel = 3'b001; ID_rs1 = 5'd7;
    #1;
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL load_use_unused ctl=%b expected=%b", ctl, 8'h00);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (stall_cnt !== 16'd1) begin
      fails++; $display("FAIL load_use_cnt stall=%0d expected=1", stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    load_use_inputs(5'd5, 3'b001);
    EX_br_taken = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'b0001_1000) begin
      fails++; $display("FAIL branch_ctl ctl=%b expected=%b", ctl, 8'b0001_1000);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      fails++; $display("FAIL branch_cnt flush=%0d stall=%0d expected=1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mdu();
    int starts;
    do_reset();
    starts = 0;
    EX_mdu_op = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'b1110_0110) begin
      fails++; $display("FAIL mdu_start_ctl ctl=%b expected=%b", ctl, 8'b1110_0110);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      // Branch and load-use presented mid-operation must be ignored.
      EX_br_taken = (i == 3);
      if (i == 4) load_use_inputs(5'd5, 3'b001);
      #1;
      if (mdu_start) starts++;
      tests++;
      if (ctl !== 8'b1110_0100) begin
        fails++; $display("FAIL mdu_busy_ctl cycle=%0d ctl=%b expected=%b", i, ctl, 8'b1110_0100);
      end
    end
    tests++;
    if (starts !== 0) begin
      fails++; $display("FAIL mdu_start_repeat count=%0d expected=0", starts);
    end
    @(negedge clk);
    idle();
    EX_mdu_op = 1'b1;
    mdu_done = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL mdu_done_release ctl=%b expected=%b", ctl, 8'h00);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (stall_cnt !== 16'd6 || ctl !== 8'h00) begin
      fails++; $display("FAIL mdu_stall_cnt stall=%0d ctl=%b expected=6/00000000", stall_cnt, ctl);
    end
  endtask

  task automatic test_halt_in_mdu();
    do_reset();
    EX_mdu_op = 1'b1;
    @(negedge clk);
    halt_req = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'b1110_0100) begin
      fails++; $display("FAIL halt_deferred ctl=%b expected=%b", ctl, 8'b1110_0100);
    end
    @(negedge clk);
    mdu_done = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL halt_mdu_done ctl=%b expected=%b", ctl, 8'h00);
    end
    @(negedge clk);
    mdu_done = 1'b0; EX_mdu_op = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'b1110_0101) begin
      fails++; $display("FAIL halt_entered ctl=%b expected=%b", ctl, 8'b1110_0101);
    end
    // A stray mdu_done while halted changes nothing.
    @(negedge clk);
    mdu_done = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'b1110_0101) begin
      fails++; $display("FAIL halt_stray_done ctl=%b expected=%b", ctl, 8'b1110_0101);
    end
    @(negedge clk);
    mdu_done = 1'b0; halt_req = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL halt_release ctl=%b expected=%b", ctl, 8'h00);
    end
    @(negedge clk);
    #1;
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL halt_run_after ctl=%b expected=%b", ctl, 8'h00);
    end
  endtask

  task automatic test_reset_in_mdu();
    do_reset();
    EX_mdu_op = 1'b1;
    @(negedge clk);
    EX_mdu_op = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'h00 || stall_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_mdu_async ctl=%b stall=%0d expected=00000000/0", ctl, stall_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    mdu_done = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL reset_mdu_stray ctl=%b expected=%b", ctl, 8'h00);
    end
    @(negedge clk);
    mdu_done = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'h00 || stall_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_mdu_after ctl=%b stall=%0d expected=00000000/0", ctl, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    halt_req = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    tests++;
    if (stall_cnt4 !== 4'd15) begin
      fails++; $display("FAIL sat_cnt4 stall=%0d expected=15", stall_cnt4);
    end
    tests++;
    if (stall_cnt !== 16'd20) begin
      fails++; $display("FAIL sat_cnt16 stall=%0d expected=20", stall_cnt);
    end
    // Reset while halted returns straight to RUN.
    rstn = 1'b0;
    #1;
    tests++;
    if (halted !== 1'b0 || stall_cnt4 !== 4'd0) begin
      fails++; $display("FAIL sat_reset halted=%b stall4=%0d expected=0/0", halted, stall_cnt4);
    end
    @(negedge clk);
    idle();
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_halt_in_mdu();
    test_reset_in_mdu();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
